// File: rtl/vram_pkg.sv
// Shared VRAM geometry, colour type and fill-engine state encoding.
// The VGA reader and rect_fill both import this package.
package vram_pkg;
    localparam int          H_PIXELS_DEF  = 160;
    localparam int          V_PIXELS_DEF  = 120;
    localparam logic [15:0] BASE_ADDR_DEF = 16'h8000;

    typedef logic [11:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;
endpackage

// File: rtl/vram_addr_calc.sv
// Start address of a rectangle: BASE_ADDR + y*H_PIXELS + x, built as a constant shift-add.
// Used only in SETUP, so it stays out of the per-pixel loop.
module vram_addr_calc
    import vram_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          H_PIXELS  = H_PIXELS_DEF
) (
    input  logic [7:0]  i_x,
    input  logic [6:0]  i_y,
    output logic [15:0] o_addr
);
    localparam logic [15:0] H_W = 16'(H_PIXELS);

    logic [15:0] w_row_off;

    always_comb begin
        w_row_off = '0;
        for (int i = 0; i < 16; i++) begin
            if (H_W[i]) w_row_off = w_row_off + ({9'd0, i_y} << i);
        end
    end

    assign o_addr = BASE_ADDR + w_row_off + {8'd0, i_x};
endmodule

// File: rtl/rect_fill.sv
// Solid rectangle fill into VRAM, clipped to the framebuffer, one word per cycle.
//   state | meaning
//   IDLE  | ready for a command (once out of reset)
//   SETUP | clip extents, compute start address
//   WRITE | emit one pixel write per cycle, row-major
//   DONE  | one-cycle completion pulse
module rect_fill
    import vram_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          H_PIXELS  = H_PIXELS_DEF,
    parameter int          V_PIXELS  = V_PIXELS_DEF
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    input  logic [7:0]  cmd_w,
    input  logic [6:0]  cmd_h,
    input  color_t      cmd_color,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        done
);
    localparam logic [8:0]  H_LIM  = 9'(H_PIXELS);
    localparam logic [7:0]  V_LIM  = 8'(V_PIXELS);
    localparam logic [15:0] H_STEP = 16'(H_PIXELS);

    fill_state_t r_state, w_next;
    logic        r_armed;
    logic [7:0]  r_x, r_w;
    logic [6:0]  r_y, r_h;
    color_t      r_color;
    logic [15:0] r_addr, r_row_base;
    logic [8:0]  r_wc, r_col_left;
    logic [7:0]  r_row_left;

    logic [8:0]  w_room_x, w_wc;
    logic [7:0]  w_room_y, w_hc;
    logic [15:0] w_start;
    logic        w_accept, w_last;

    vram_addr_calc #(
        .BASE_ADDR (BASE_ADDR),
        .H_PIXELS  (H_PIXELS)
    ) u_addr_calc (
        .i_x    (r_x),
        .i_y    (r_y),
        .o_addr (w_start)
    );

    assign w_room_x = H_LIM - {1'b0, r_x};
    assign w_room_y = V_LIM - {1'b0, r_y};
    assign w_wc = ({1'b0, r_x} >= H_LIM) ? 9'd0 :
                  (({1'b0, r_w} < w_room_x) ? {1'b0, r_w} : w_room_x);
    assign w_hc = ({1'b0, r_y} >= V_LIM) ? 8'd0 :
                  (({1'b0, r_h} < w_room_y) ? {1'b0, r_h} : w_room_y);

    assign w_accept = cmd_valid && cmd_ready;
    assign w_last   = (r_col_left == 9'd1) && (r_row_left == 8'd1);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Outputs are decoded from state so reset drops them without waiting for a clock.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = r_armed;
                if (cmd_valid && r_armed) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_next = ((w_wc == 9'd0) || (w_hc == 8'd0)) ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = r_addr;
                wr_data = {4'b0000, r_color};
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_armed    <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_color    <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
            r_wc       <= '0;
            r_col_left <= '0;
            r_row_left <= '0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x     <= cmd_x;
                        r_y     <= cmd_y;
                        r_w     <= cmd_w;
                        r_h     <= cmd_h;
                        r_color <= cmd_color;
                    end
                end
                ST_SETUP: begin
                    r_addr     <= w_start;
                    r_row_base <= w_start;
                    r_wc       <= w_wc;
                    r_col_left <= w_wc;
                    r_row_left <= w_hc;
                end
                ST_WRITE: begin
                    // End of a row: step the row base by one line instead of multiplying.
                    if (r_col_left == 9'd1) begin
                        r_row_base <= r_row_base + H_STEP;
                        r_addr     <= r_row_base + H_STEP;
                        r_col_left <= r_wc;
                        r_row_left <= r_row_left - 8'd1;
                    end else begin
                        r_addr     <= r_addr + 16'd1;
                        r_col_left <= r_col_left - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: vector table plus back-to-back and mid-operation reset sequences.
module tb_rect_fill;
    logic        clock = 1'b0;
    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x, cmd_w;
    logic [6:0]  cmd_y, cmd_h;
    logic [11:0] cmd_color;
    logic [15:0] wr_addr, wr_data;
    logic        wr_en, busy, done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] wq[$];
    int done_cnt = 0;
    int dbl_done = 0;
    int idle_bad = 0;
    int busy_ready = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [7:0]  w;
        logic [6:0]  h;
        logic [11:0] color;
        int          n;
        logic [15:0] first;
        logic [15:0] last;
        int          lat;
    } vec_t;
    vec_t vecs[9];

    rect_fill dut (
        .clock     (clock),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (wr_en) wq.push_back({wr_addr, wr_data});
        else if (wr_addr != 16'd0 || wr_data != 16'd0) idle_bad <= idle_bad + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done && prev_done) dbl_done <= dbl_done + 1;
        if (busy && cmd_ready) busy_ready <= busy_ready + 1;
        prev_done <= done;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Called right after a negedge; returns at the negedge where done is seen.
    task automatic run_cmd(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                           input logic [6:0] h, input logic [11:0] color, output int lat);
        int acc;
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = color;
        cmd_valid = 1'b1;
        acc = -1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clock);
        end
        if (acc < 0) begin
            cmd_valid = 1'b0;
            timeout_fail("accept");
            return;
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_x = 8'($urandom); cmd_y = 7'($urandom); cmd_w = 8'($urandom);
        cmd_h = 7'($urandom); cmd_color = 12'($urandom);
        for (int i = 0; i < 25000; i++) begin
            @(negedge clock);
            if (done) begin
                lat = cyc - acc;
                break;
            end
        end
        if (lat < 0) timeout_fail("done");
    endtask

    initial begin
        int lat, wc, hc, k, seq_err, data_err, cnt, acc1, d1, acc2, bad0, d0;
        logic [15:0] exp_a;

        vecs[0] = '{8'd0,   7'd0,   8'd2,   7'd2,   12'hF00, 4,     16'h8000, 16'h80A1, 6};
        vecs[1] = '{8'd158, 7'd119, 8'd5,   7'd3,   12'hABC, 2,     16'hCAFE, 16'hCAFF, 4};
        vecs[2] = '{8'd10,  7'd5,   8'd0,   7'd3,   12'h555, 0,     16'h0000, 16'h0000, 2};
        vecs[3] = '{8'd160, 7'd0,   8'd4,   7'd4,   12'h777, 0,     16'h0000, 16'h0000, 2};
        vecs[4] = '{8'd0,   7'd120, 8'd3,   7'd3,   12'h0F0, 0,     16'h0000, 16'h0000, 2};
        vecs[5] = '{8'd5,   7'd10,  8'd3,   7'd2,   12'h0F0, 6,     16'h8645, 16'h86E7, 8};
        vecs[6] = '{8'd159, 7'd0,   8'd1,   7'd1,   12'h00F, 1,     16'h809F, 16'h809F, 3};
        vecs[7] = '{8'd100, 7'd117, 8'd255, 7'd10,  12'h123, 180,   16'hC984, 16'hCAFF, 182};
        vecs[8] = '{8'd0,   7'd0,   8'd255, 7'd127, 12'hFFF, 19200, 16'h8000, 16'hCAFF, 19202};

        clear = 1'b0; cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", {wr_en, done, wr_addr, wr_data}, 0);
        clear = 1'b1;
        #1 check("ready_before_edge", cmd_ready, 0);
        @(posedge clock);
        #1 check("ready_after_edge", cmd_ready, 1);
        @(negedge clock);

        for (int v = 0; v < 9; v++) begin
            wq.delete();
            run_cmd(vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h, vecs[v].color, lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_nwrites", v), wq.size(), vecs[v].n);
            if (vecs[v].n > 0 && wq.size() > 0) begin
                check($sformatf("v%0d_first", v), wq[0][31:16], vecs[v].first);
                check($sformatf("v%0d_last", v), wq[wq.size()-1][31:16], vecs[v].last);
            end
            wc = (vecs[v].x >= 160) ? 0 : ((vecs[v].w < 160 - vecs[v].x) ? vecs[v].w : 160 - vecs[v].x);
            hc = (vecs[v].y >= 120) ? 0 : ((vecs[v].h < 120 - vecs[v].y) ? vecs[v].h : 120 - vecs[v].y);
            k = 0; seq_err = 0; data_err = 0;
            for (int r = 0; r < hc; r++) begin
                for (int c = 0; c < wc; c++) begin
                    exp_a = 16'((32'h8000 + (vecs[v].y + r) * 160 + vecs[v].x + c) & 32'hFFFF);
                    if (k < wq.size()) begin
                        if (wq[k][31:16] !== exp_a) seq_err++;
                        if (wq[k][15:0] !== {4'b0000, vecs[v].color}) data_err++;
                    end
                    k++;
                end
            end
            if (vecs[v].n > 0) begin
                check($sformatf("v%0d_addr_seq_errors", v), seq_err, 0);
                check($sformatf("v%0d_data_errors", v), data_err, 0);
            end
        end

        // Back-to-back: valid held high across the whole first command.
        wq.delete();
        bad0 = busy_ready;
        cmd_x = 8'd0; cmd_y = 7'd0; cmd_w = 8'd2; cmd_h = 7'd1; cmd_color = 12'h111;
        cmd_valid = 1'b1;
        acc1 = -1; d1 = -1; acc2 = -1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                acc1 = cyc;
                break;
            end
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        cmd_x = 8'd1; cmd_y = 7'd1; cmd_w = 8'd1; cmd_h = 7'd1; cmd_color = 12'h222;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done) d1 = cyc;
            if (cmd_ready && cmd_valid) begin
                acc2 = cyc;
                break;
            end
        end
        if (acc1 < 0 || acc2 < 0) timeout_fail("b2b_accept");
        check("b2b_first_latency", d1 - acc1, 4);
        check("b2b_accept_after_done", acc2, d1 + 1);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done) begin
                lat = cyc - acc2;
                break;
            end
        end
        check("b2b_second_latency", lat, 3);
        check("b2b_nwrites", wq.size(), 3);
        if (wq.size() == 3) begin
            check("b2b_w1", wq[1], {16'h8001, 16'h0111});
            check("b2b_w2", wq[2], {16'h80A1, 16'h0222});
        end
        check("b2b_ready_while_busy", busy_ready - bad0, 0);

        // Reset during the third write of a 4x4 fill.
        @(negedge clock);
        wq.delete();
        cmd_x = 8'd0; cmd_y = 7'd0; cmd_w = 8'd4; cmd_h = 7'd4; cmd_color = 12'h0AA;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clock);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (wr_en) cnt++;
            if (cnt == 3) break;
        end
        check("rst_mid_reached_w3", cnt, 3);
        d0 = done_cnt;
        #2 clear = 1'b0;
        #1;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", cmd_ready, 0);
        check("rst_mid_addr", wr_addr, 0);
        repeat (3) @(negedge clock);
        clear = 1'b1;
        #1 check("rst_mid_ready_pre_edge", cmd_ready, 0);
        @(posedge clock);
        #1 check("rst_mid_ready_post_edge", cmd_ready, 1);
        repeat (3) @(negedge clock);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_nwrites", wq.size(), 3);

        @(negedge clock);
        check("idle_outputs_nonzero", idle_bad, 0);
        check("done_wider_than_1", dbl_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h8000: VRAM word address of pixel (0,0).
REQ-002 SHALL have parameter H_PIXELS, default 160: framebuffer width in words/pixels.
REQ-003 SHALL have parameter V_PIXELS, default 120: framebuffer height in rows.
REQ-004 SHALL have ports, in this order:
- clock  in  1: single clock.
- clear  in  1: asynchronous, active-low reset.
- cmd_valid  in  1: command present.
- cmd_ready  out  1: command accepted on valid & ready.
- cmd_x  in  8: left column.
- cmd_y  in  7: top row.
- cmd_w  in  8: width in pixels.
- cmd_h  in  7: height in rows.
- cmd_color  in  12: RGB 4:4:4 fill colour.
- wr_addr  out  16: VRAM write address.
- wr_data  out  16: VRAM write data.
- wr_en  out  1: write strobe, one word per cycle.
- busy  out  1: command in progress.
- done  out  1: one-cycle completion pulse.

Function
REQ-005 SHALL implement FSM IDLE -> SETUP -> WRITE -> DONE -> IDLE.
REQ-006 SHALL drive cmd_ready=1 only in IDLE, and SHALL capture all cmd_* fields on the cycle valid & ready is high.
REQ-007 SHALL ignore cmd_* changes after capture.
REQ-008 SHALL compute the clipped extents in SETUP:
- wc = min(w, H_PIXELS-x); hc = min(h, V_PIXELS-y).
- wc or hc SHALL be 0 if x>=H_PIXELS or y>=V_PIXELS.
REQ-009 SHALL go SETUP -> DONE directly, issuing no writes, if wc=0 or hc=0.
REQ-010 SHALL issue exactly wc*hc writes in WRITE, one per cycle with wr_en=1, in row-major order: left to right, then top to bottom.
REQ-011 SHALL compute each write address as BASE_ADDR + row*H_PIXELS + col, modulo 2^16.
REQ-012 SHALL compute the row base incrementally (previous row base + H_PIXELS), with no multiplier in the WRITE loop.
REQ-013 SHALL drive wr_data = {4'b0000, captured colour} during writes.
REQ-014 SHALL go WRITE -> DONE in the cycle after the last write.
REQ-015 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-016 SHALL assert busy=1 in SETUP, WRITE and DONE, and 0 in IDLE.
REQ-017 SHALL complete a non-empty command in 1 + wc*hc + 1 cycles after the acceptance edge; an empty command SHALL take 2 cycles.
REQ-018 SHALL allow the next command to be accepted on the first IDLE cycle after DONE; commands SHALL NOT overlap.
REQ-019 SHALL hold wr_en=0, done=0, wr_addr=0 and wr_data=0 whenever not writing.

Reset
REQ-020 SHALL, while clear=0, immediately force: state=IDLE, cmd_ready=0, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-021 SHALL assert cmd_ready on the first clock edge after clear rises.
REQ-022 SHALL abandon an in-progress command on reset mid-operation, with no done pulse and no further writes.

Structure
REQ-023 SHALL take H_PIXELS, V_PIXELS, BASE_ADDR defaults, the 12-bit colour typedef and the FSM state enum from shared package vram_pkg, which the VGA reader also uses.
REQ-024 SHALL place the SETUP start-address computation (BASE_ADDR + y*H_PIXELS + x, shift-add) in sub-module vram_addr_calc.

Verification
REQ-025 SHALL cover a 2x2 fill: x=0, y=0, w=2, h=2, colour 12'hF00 -> writes 8000, 8001, 80A0, 80A1, all with data 0F00; done 6 cycles after acceptance.
REQ-026 SHALL cover clipping: x=158, y=119, w=5, h=3 -> exactly 2 writes, to CAFE then CAFF; done 4 cycles after acceptance.
REQ-027 SHALL cover empty commands: w=0, and separately x=160 -> no wr_en; done 2 cycles after acceptance.
REQ-028 SHALL cover back-to-back commands: cmd_valid held high through busy -> cmd_ready=0 while busy; second command accepted the cycle after done.
REQ-029 SHALL cover reset mid-operation: clear driven low during the 3rd write of a 4x4 fill -> wr_en and busy drop with no clock edge; no done pulse; cmd_ready=1 one edge after clear returns high.
REQ-030 SHALL cover a full-screen fill: x=0, y=0, w=255, h=127 -> 19200 writes, last to CAFF; done 19202 cycles after acceptance.
